// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit producing per-stage stall/flush controls with optional perf counters.
// Ports: clk, rst (async, active-high); rsD/rtD decode sources; rtE/memtoregE/regwriteE execute load info;
//   branch_takenD; div_startE/div_done divider handshake; mem_reqM/mem_ack memory handshake; excM exception;
//   stallF/D/E/M and flushD/E/M/W pipeline-register controls; stall_cycles/flush_count perf counters.
// Build option: define HAZARD_PERF_CNT_EN to enable the saturating perf counters (otherwise tied to 0).
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rtE,
  input  logic             memtoregE,
  input  logic             regwriteE,
  input  logic             branch_takenD,
  input  logic             div_startE,
  input  logic             div_done,
  input  logic             mem_reqM,
  input  logic             mem_ack,
  input  logic             excM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [1:0] RUN = 2'd0, DIV_WAIT = 2'd1, MEM_WAIT = 2'd2;
  logic [1:0] state, state_nx;
  logic load_use, mem_busy, div_busy;
  assign load_use = memtoregE & regwriteE & (rtE != '0) & ((rtE == rsD) | (rtE == rtD));
  // Once a wait is entered it is held until its completion strobe, even if the request drops early.
  assign mem_busy = (mem_reqM | (state == MEM_WAIT)) & ~mem_ack;
  assign div_busy = (div_startE | (state == DIV_WAIT)) & ~div_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_nx;
  // A divide that coincides with a memory wait falls through to DIV_WAIT on the ack cycle.
  always_comb state_nx = excM ? RUN : mem_busy ? MEM_WAIT : div_busy ? DIV_WAIT : RUN;
  always_comb begin
    stallM = ~rst & ~excM & mem_busy;
    stallE = ~rst & ~excM & (mem_busy | div_busy);
    stallD = ~rst & ~excM & (mem_busy | div_busy | load_use);
    stallF = stallD;
    flushW = ~rst & (excM | mem_busy);
    flushM = ~rst & (excM | (~mem_busy & div_busy));
    flushE = ~rst & (excM | (~mem_busy & ~div_busy & load_use));
    flushD = ~rst & (excM | (branch_takenD & ~stallD));
  end
`ifdef HAZARD_PERF_CNT_EN
  logic any_flush;
  assign any_flush = flushD | flushE | flushM | flushW;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= stall_cycles + CNT_W'(stallF & ~&stall_cycles);
      flush_count  <= flush_count + CNT_W'(any_flush & ~&flush_count);
    end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;
  localparam logic [1:0] RUN = 2'd0, DIV = 2'd1, MEM = 2'd2;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rsD, rtD, rtE;
  logic memtoregE, regwriteE, branch_takenD, div_startE, div_done, mem_reqM, mem_ack, excM;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic [31:0] stall_cycles, flush_count;
  int n_chk = 0, n_fail = 0;
  int exp_stall = 0, exp_flush = 0;
  wire [7:0] outs = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW};
  hazard_ctrl dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rtE(rtE), .memtoregE(memtoregE),
    .regwriteE(regwriteE), .branch_takenD(branch_takenD), .div_startE(div_startE),
    .div_done(div_done), .mem_reqM(mem_reqM), .mem_ack(mem_ack), .excM(excM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear();
    {rsD, rtD, rtE} = '0;
    {memtoregE, regwriteE, branch_takenD, div_startE, div_done, mem_reqM, mem_ack, excM} = '0;
  endtask
  task automatic cyc(string tag, logic [7:0] eo, logic [1:0] es);
    check({tag, "_stall_cnt"}, stall_cycles, PERF ? 32'(exp_stall) : 32'd0);
    check({tag, "_flush_cnt"}, flush_count, PERF ? 32'(exp_flush) : 32'd0);
    #1;
    check({tag, "_outs"}, 32'(outs), 32'(eo));
    check({tag, "_state"}, 32'(dut.state), 32'(es));
    exp_stall += int'(eo[7]);
    exp_flush += int'(|eo[3:0]);
    @(negedge clk);
  endtask
  initial begin
    clear();
    mem_reqM = 1'b1;
    #2;
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_state", 32'(dut.state), 32'(RUN));
    check("rst_cnt", stall_cycles | flush_count, 32'd0);
    @(negedge clk);
    clear();
    rst = 1'b0;
    cyc("idle", 8'h00, RUN);
    memtoregE = 1; regwriteE = 1; rtE = 8; rsD = 8;
    cyc("lu", 8'hC4, RUN);
    clear();
    cyc("lu_end", 8'h00, RUN);
    memtoregE = 1; regwriteE = 1;
    cyc("lu_r0", 8'h00, RUN);
    rtE = 3; rtD = 3;
    cyc("lu_rt", 8'hC4, RUN);
    regwriteE = 0;
    cyc("lu_nowr", 8'h00, RUN);
    clear();
    branch_takenD = 1;
    cyc("br", 8'h08, RUN);
    memtoregE = 1; regwriteE = 1; rtE = 8; rsD = 8;
    cyc("br_lu", 8'hC4, RUN);
    clear();
    div_startE = 1;
    for (int i = 0; i < 10; i++) cyc("div", 8'hE2, i == 0 ? RUN : DIV);
    div_done = 1;
    cyc("div_done", 8'h00, DIV);
    clear();
    cyc("div_after", 8'h00, RUN);
    mem_reqM = 1; div_startE = 1;
    for (int i = 0; i < 3; i++) cyc("mem", 8'hF1, i == 0 ? RUN : MEM);
    mem_ack = 1;
    cyc("mem_ack", 8'hE2, MEM);
    mem_reqM = 0; mem_ack = 0;
    cyc("div2", 8'hE2, DIV);
    excM = 1;
    cyc("exc", 8'h0F, DIV);
    clear();
    cyc("exc_after", 8'h00, RUN);
    mem_reqM = 1;
    cyc("mem_r", 8'hF1, RUN);
    cyc("mem_r2", 8'hF1, MEM);
    #2 rst = 1'b1;
    #1;
    check("arst_outs", 32'(outs), 32'd0);
    check("arst_state", 32'(dut.state), 32'(RUN));
    check("arst_stall_cnt", stall_cycles, 32'd0);
    check("arst_flush_cnt", flush_count, 32'd0);
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    clear();
    rst = 1'b0;
    cyc("post_rst", 8'h00, RUN);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
